// File: rtl/pm_entry_tx.sv
// Requester half of the RDI PM-entry handshake: sends Req.L1/Req.L2, waits for
// Rsp/PMNAK under a clock-dependent timeout, and reports done/nak to the RDI FSM.
`timescale 1ns/1ps
module pm_entry_tx #(
  parameter int unsigned TMO_100M = 1000,
  parameter int unsigned TMO_200M = 2000,
  parameter int unsigned CNT_W    = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_req_L1_or_L2,
  input  logic       i_clk_div_ratio,
  input  logic       i_msg_done,
  input  logic       i_msg_valid,
  input  logic [3:0] i_msg_no,
  output logic       o_msg_valid,
  output logic [3:0] o_msg_no,
  output logic       o_test_done,
  output logic       o_pm_nak,
  output logic       o_force_exit
);

  localparam logic [3:0] MSG_REQ_L1 = 4'd2;
  localparam logic [3:0] MSG_REQ_L2 = 4'd3;
  localparam logic [3:0] MSG_PMNAK  = 4'd9;
  localparam logic [3:0] MSG_RSP_L1 = 4'd10;
  localparam logic [3:0] MSG_RSP_L2 = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_REQ = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_l2, req_l2_nxt;
  logic             div_200m, div_200m_nxt;
  logic             msg_valid_nxt;
  logic [3:0]       msg_no_nxt;
  logic             test_done_nxt;
  logic             pm_nak_nxt;
  logic             force_exit_nxt;

  logic [CNT_W-1:0] tmo_limit;
  logic [3:0]       rsp_expected;
  logic             rsp_ok, rsp_nak, rsp_accept, timeout;

  // Response decode; a response always beats a coincident timeout.
  assign tmo_limit    = div_200m ? CNT_W'(TMO_200M) : CNT_W'(TMO_100M);
  assign rsp_expected = req_l2 ? MSG_RSP_L2 : MSG_RSP_L1;
  assign rsp_ok       = i_msg_valid && (i_msg_no == rsp_expected);
  assign rsp_nak      = i_msg_valid && (i_msg_no == MSG_PMNAK);
  assign rsp_accept   = ((state == SEND_REQ) || (state == WAIT_RSP)) && (rsp_ok || rsp_nak);
  assign timeout      = (state == WAIT_RSP) && (cnt == tmo_limit) && !rsp_accept;

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      req_l2       <= 1'b0;
      div_200m     <= 1'b0;
      o_msg_valid  <= 1'b0;
      o_msg_no     <= '0;
      o_test_done  <= 1'b0;
      o_pm_nak     <= 1'b0;
      o_force_exit <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      req_l2       <= req_l2_nxt;
      div_200m     <= div_200m_nxt;
      o_msg_valid  <= msg_valid_nxt;
      o_msg_no     <= msg_no_nxt;
      o_test_done  <= test_done_nxt;
      o_pm_nak     <= pm_nak_nxt;
      o_force_exit <= force_exit_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    if (!i_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = SEND_REQ;
        SEND_REQ: begin
          if (rsp_accept)      state_nxt = DONE;
          else if (i_msg_done) state_nxt = WAIT_RSP;
        end
        WAIT_RSP: if (rsp_accept || timeout) state_nxt = DONE;
        DONE:     state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin : output_logic
    msg_valid_nxt  = o_msg_valid;
    msg_no_nxt     = o_msg_no;
    test_done_nxt  = o_test_done;
    pm_nak_nxt     = o_pm_nak;
    force_exit_nxt = 1'b0;
    cnt_nxt        = cnt;
    req_l2_nxt     = req_l2;
    div_200m_nxt   = div_200m;
    if (!i_en) begin
      msg_valid_nxt = 1'b0;
      msg_no_nxt    = '0;
      test_done_nxt = 1'b0;
      pm_nak_nxt    = 1'b0;
      cnt_nxt       = '0;
    end else begin
      case (state)
        IDLE: begin
          req_l2_nxt    = i_req_L1_or_L2;
          div_200m_nxt  = i_clk_div_ratio;
          msg_valid_nxt = 1'b1;
          msg_no_nxt    = i_req_L1_or_L2 ? MSG_REQ_L2 : MSG_REQ_L1;
        end
        SEND_REQ: begin
          if (rsp_accept) begin
            msg_valid_nxt = 1'b0;
            test_done_nxt = 1'b1;
            pm_nak_nxt    = rsp_nak;
          end else if (i_msg_done) begin
            msg_valid_nxt = 1'b0;
            cnt_nxt       = '0;
          end
        end
        WAIT_RSP: begin
          if (rsp_accept) begin
            test_done_nxt = 1'b1;
            pm_nak_nxt    = rsp_nak;
          end else if (timeout) begin
            test_done_nxt  = 1'b1;
            pm_nak_nxt     = 1'b1;
            force_exit_nxt = 1'b1;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_entry_tx.sv
// Randomized bench for pm_entry_tx against a timestamp-based handshake model.
`timescale 1ns/1ps
module tb_pm_entry_tx;

  localparam int unsigned TMO_100M = 1000;
  localparam int unsigned TMO_200M = 2000;
  localparam int unsigned CNT_W    = 12;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, req, div, msg_done, msg_valid_in;
  logic [3:0] msg_no_in;
  logic       msg_valid_out;
  logic [3:0] msg_no_out;
  logic       test_done, pm_nak, force_exit;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: flow progress plus the absolute cycle at which the timeout fires.
  int cyc = 0;
  int m_phase, m_limit, m_deadline, m_no;
  bit m_req_l2, m_valid, m_no_known, m_td, m_nak, m_fx;

  pm_entry_tx #(.TMO_100M(TMO_100M), .TMO_200M(TMO_200M), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_req_L1_or_L2  (req),
    .i_clk_div_ratio (div),
    .i_msg_done      (msg_done),
    .i_msg_valid     (msg_valid_in),
    .i_msg_no        (msg_no_in),
    .o_msg_valid     (msg_valid_out),
    .o_msg_no        (msg_no_out),
    .o_test_done     (test_done),
    .o_pm_nak        (pm_nak),
    .o_force_exit    (force_exit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase    = PH_IDLE;
    m_valid    = 1'b0;
    m_no       = 0;
    m_no_known = 1'b1;
    m_td       = 1'b0;
    m_nak      = 1'b0;
    m_fx       = 1'b0;
  endtask

  task automatic model_finish(input bit nak);
    m_valid    = 1'b0;
    m_no_known = 1'b0;
    m_td       = 1'b1;
    m_nak      = nak;
    m_phase    = PH_DONE;
  endtask

  task automatic model_step();
    logic [3:0] want;
    bit hit;
    cyc++;
    m_fx = 1'b0;
    if (!en) begin
      model_clear();
      return;
    end
    want = m_req_l2 ? 4'd11 : 4'd10;
    hit  = msg_valid_in && ((msg_no_in == want) || (msg_no_in == 4'd9));
    case (m_phase)
      PH_IDLE: begin
        m_req_l2   = req;
        m_limit    = div ? int'(TMO_200M) : int'(TMO_100M);
        m_valid    = 1'b1;
        m_no       = req ? 3 : 2;
        m_no_known = 1'b1;
        m_phase    = PH_REQ;
      end
      PH_REQ: begin
        if (hit) model_finish(msg_no_in == 4'd9);
        else if (msg_done) begin
          m_valid    = 1'b0;
          m_no_known = 1'b0;
          m_deadline = cyc + 1 + m_limit;
          m_phase    = PH_WAIT;
        end
      end
      PH_WAIT: begin
        if (hit) model_finish(msg_no_in == 4'd9);
        else if (cyc == m_deadline) begin
          model_finish(1'b1);
          m_fx = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("msg_valid", int'(msg_valid_out), int'(m_valid));
    if (m_no_known) check_eq("msg_no", int'(msg_no_out), m_no);
    check_eq("test_done", int'(test_done), int'(m_td));
    check_eq("pm_nak", int'(pm_nak), int'(m_nak));
    check_eq("force_exit", int'(force_exit), int'(m_fx));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_msg_valid"}, int'(msg_valid_out), 0);
    check_eq({tag, "_msg_no"}, int'(msg_no_out), 0);
    check_eq({tag, "_test_done"}, int'(test_done), 0);
    check_eq({tag, "_pm_nak"}, int'(pm_nak), 0);
    check_eq({tag, "_force_exit"}, int'(force_exit), 0);
  endtask

  // Any code except PMNAK and the currently expected response.
  function automatic logic [3:0] noise_code();
    logic [3:0] c;
    logic [3:0] want;
    want = m_req_l2 ? 4'd11 : 4'd10;
    do c = 4'($urandom_range(0, 15)); while (c == 4'd9 || c == want);
    return c;
  endfunction

  task automatic drive_noise();
    msg_valid_in = 1'($urandom_range(0, 1));
    msg_no_in    = noise_code();
  endtask

  // mode 0: ignored codes then Rsp; 1: PMNAK; 2: timeout; 3: Rsp on the timeout
  // cycle; 4: enable drop during the request; 5: Rsp while the request is pending.
  task automatic run_flow(input int mode, input bit req_v, input bit div_v);
    logic [3:0] want;
    want     = req_v ? 4'd11 : 4'd10;
    en       = 1'b1;
    req      = req_v;
    div      = div_v;
    msg_done = 1'b0;
    msg_valid_in = 1'b0;
    tick();
    repeat ($urandom_range(0, 4)) begin
      drive_noise();
      tick();
    end
    if (mode == 4) begin
      drive_noise();
      msg_done = 1'($urandom_range(0, 1));
      en = 1'b0;
      tick();
      msg_done = 1'b0;
      msg_valid_in = 1'b0;
      tick();
      return;
    end
    if (mode == 5) begin
      msg_valid_in = 1'b1;
      msg_no_in    = want;
      msg_done     = 1'($urandom_range(0, 1));
      tick();
      msg_done = 1'b0;
    end else begin
      msg_done = 1'b1;
      drive_noise();
      tick();
      msg_done = 1'b0;
      case (mode)
        0, 1: begin
          repeat ($urandom_range(0, 10)) begin
            drive_noise();
            tick();
          end
          msg_valid_in = 1'b1;
          msg_no_in    = req_v ? 4'd10 : 4'd11;
          tick();
          msg_no_in    = req_v ? 4'd3 : 4'd2;
          tick();
          msg_no_in    = (mode == 1) ? 4'd9 : want;
          tick();
        end
        2: begin
          for (int i = 0; i < int'(TMO_200M) + 10 && m_phase != PH_DONE; i++) begin
            drive_noise();
            tick();
          end
        end
        default: begin
          for (int i = 0; i < int'(TMO_200M) + 10 && (cyc + 1) != m_deadline; i++) begin
            drive_noise();
            tick();
          end
          msg_valid_in = 1'b1;
          msg_no_in    = want;
          tick();
        end
      endcase
    end
    repeat ($urandom_range(1, 4)) begin
      msg_valid_in = 1'($urandom_range(0, 1));
      msg_no_in    = 4'($urandom_range(9, 11));
      tick();
    end
    msg_valid_in = 1'b0;
    en = 1'b0;
    tick();
  endtask

  task automatic reset_in_wait();
    en  = 1'b1;
    req = 1'b1;
    div = 1'b0;
    tick();
    msg_done = 1'b1;
    tick();
    msg_done = 1'b0;
    repeat (50) begin
      drive_noise();
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    en = 1'b0;
    msg_valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en  = 1'b1;
    req = 1'b0;
    repeat (TMO_100M + 20) tick();
    en = 1'b0;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; req = 1'b0; div = 1'b0;
    msg_done = 1'b0; msg_valid_in = 1'b0; msg_no_in = 4'd0;
    model_clear();
    m_req_l2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_flow(0, 1'b0, 1'b0);
    run_flow(1, 1'b1, 1'b1);
    run_flow(2, 1'b0, 1'b0);
    run_flow(3, 1'b0, 1'b0);
    run_flow(5, 1'b1, 1'b0);
    run_flow(4, 1'b1, 1'b0);
    reset_in_wait();

    for (int n = 0; n < 18; n++) begin
      run_flow(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
